// File: rtl/issue_select_if.sv
// Issue-select bus: slot request/payload side, grant feedback, issue ports and wakeup ports.
interface issue_select_if #(
  parameter int unsigned NUM_SLOTS   = 8,
  parameter int unsigned ISSUE_WIDTH = 2
) ();

  localparam int unsigned IDX_W  = $clog2(NUM_SLOTS);
  localparam int unsigned PDST_W = 7;

  // Slot side
  logic [NUM_SLOTS-1:0]                     slot_request;
  logic [NUM_SLOTS-1:0][PDST_W-1:0]         slot_pdst;
  logic [NUM_SLOTS-1:0]                     slot_dst_valid;
  logic [NUM_SLOTS-1:0]                     slot_grant;

  // Functional-unit side
  logic [ISSUE_WIDTH-1:0]                   fu_ready;
  logic                                     flush;
  logic [ISSUE_WIDTH-1:0]                   issue_valid;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]        issue_slot_idx;
  logic [ISSUE_WIDTH-1:0][PDST_W-1:0]       issue_pdst;

  // Wakeup broadcast back to the slots
  logic [ISSUE_WIDTH-1:0]                   wakeup_valid;
  logic [ISSUE_WIDTH-1:0][PDST_W-1:0]       wakeup_pdst;

  // Drives requests and consumes grants/issues (slots + FU environment)
  modport master (
    output slot_request, slot_pdst, slot_dst_valid, fu_ready, flush,
    input  slot_grant, issue_valid, issue_slot_idx, issue_pdst,
           wakeup_valid, wakeup_pdst
  );

  // The selector itself
  modport slave (
    input  slot_request, slot_pdst, slot_dst_valid, fu_ready, flush,
    output slot_grant, issue_valid, issue_slot_idx, issue_pdst,
           wakeup_valid, wakeup_pdst
  );

endinterface

// File: rtl/issue_select.sv
// Round-robin multi-port issue selector with registered issue ports and a
// fixed-latency wakeup broadcast pipeline.
module issue_select #(
  parameter int unsigned NUM_SLOTS      = 8,
  parameter int unsigned ISSUE_WIDTH    = 2,
  parameter int unsigned WAKEUP_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  issue_select_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_SLOTS);
  localparam int unsigned PDST_W = 7;
  localparam logic [IDX_W:0]   NUM_SLOTS_W = (IDX_W+1)'(NUM_SLOTS);
  localparam logic [IDX_W-1:0] LAST_SLOT   = IDX_W'(NUM_SLOTS - 1);

  // Round-robin search start
  logic [IDX_W-1:0] rr_ptr;

  // Combinational selection results
  logic [NUM_SLOTS-1:0]                 grant_c;
  logic [ISSUE_WIDTH-1:0]               port_vld;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]    port_idx;
  logic [ISSUE_WIDTH-1:0][PDST_W-1:0]   port_pdst;
  logic [ISSUE_WIDTH-1:0]               port_dst;
  logic [IDX_W-1:0]                     last_idx;
  logic [IDX_W-1:0]                     rr_next;
  logic                                 any_grant;
  logic                                 found;
  logic [IDX_W:0]                       pos;

  // Registered issue ports
  logic [ISSUE_WIDTH-1:0]               issue_valid_q;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]    issue_idx_q;
  logic [ISSUE_WIDTH-1:0][PDST_W-1:0]   issue_pdst_q;

  // Wakeup shift pipeline; stage WAKEUP_LATENCY-1 is the broadcast stage
  logic [WAKEUP_LATENCY-1:0][ISSUE_WIDTH-1:0]              wk_vld_q;
  logic [WAKEUP_LATENCY-1:0][ISSUE_WIDTH-1:0][PDST_W-1:0]  wk_pdst_q;

  // Ready ports in ascending order claim the next untaken requester in rotated search order
  always_comb begin
    grant_c   = '0;
    port_vld  = '0;
    port_idx  = '0;
    port_pdst = '0;
    port_dst  = '0;
    last_idx  = rr_ptr;
    any_grant = 1'b0;
    found     = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      found = 1'b0;
      if (reset && !bus.flush && bus.fu_ready[k]) begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
          if (pos >= NUM_SLOTS_W) begin
            pos = pos - NUM_SLOTS_W;
          end
          if (!found && bus.slot_request[pos[IDX_W-1:0]] && !grant_c[pos[IDX_W-1:0]]) begin
            found                     = 1'b1;
            grant_c[pos[IDX_W-1:0]]   = 1'b1;
            port_vld[k]               = 1'b1;
            port_idx[k]               = pos[IDX_W-1:0];
            port_pdst[k]              = bus.slot_pdst[pos[IDX_W-1:0]];
            port_dst[k]               = bus.slot_dst_valid[pos[IDX_W-1:0]];
            last_idx                  = pos[IDX_W-1:0];
            any_grant                 = 1'b1;
          end
        end
      end
    end
    // Later ports always land further along the search order, so the last grant is the furthest
    rr_next = (last_idx == LAST_SLOT) ? '0 : last_idx + IDX_W'(1);
  end

  // Pointer, issue registers and wakeup pipeline; flush wipes everything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr        <= '0;
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
      issue_pdst_q  <= '0;
      wk_vld_q      <= '0;
      wk_pdst_q     <= '0;
    end else if (bus.flush) begin
      rr_ptr        <= '0;
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
      issue_pdst_q  <= '0;
      wk_vld_q      <= '0;
      wk_pdst_q     <= '0;
    end else begin
      if (any_grant) begin
        rr_ptr <= rr_next;
      end
      issue_valid_q <= port_vld;
      issue_idx_q   <= port_idx;
      issue_pdst_q  <= port_pdst;
      wk_vld_q[0]   <= port_vld & port_dst;
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
        wk_pdst_q[0][k] <= (port_vld[k] && port_dst[k]) ? port_pdst[k] : '0;
      end
      for (int unsigned s = 1; s < WAKEUP_LATENCY; s++) begin
        wk_vld_q[s]  <= wk_vld_q[s-1];
        wk_pdst_q[s] <= wk_pdst_q[s-1];
      end
    end
  end

  // Output mapping
  assign bus.slot_grant     = grant_c;
  assign bus.issue_valid    = issue_valid_q;
  assign bus.issue_slot_idx = issue_idx_q;
  assign bus.issue_pdst     = issue_pdst_q;
  assign bus.wakeup_valid   = wk_vld_q[WAKEUP_LATENCY-1];
  assign bus.wakeup_pdst    = wk_pdst_q[WAKEUP_LATENCY-1];

endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Parameters
REQ-001 The block SHALL have parameter NUM_SLOTS, default 8, giving the number of issue slots arbitrated; legal range 2..32.
REQ-002 The block SHALL have parameter ISSUE_WIDTH, default 2, giving the number of issue/wakeup ports, equal to the slots' NUM_WAKEUP_PORTS.
REQ-003 The block SHALL have parameter WAKEUP_LATENCY, default 1, giving the cycles from grant to wakeup broadcast; legal range 1..4.

Interface
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 slot_request  in  NUM_SLOTS  per-slot io_request.
REQ-007 slot_pdst  in  NUM_SLOTS x 7  per-slot destination physical register.
REQ-008 slot_dst_valid  in  NUM_SLOTS  slot writes a destination.
REQ-009 fu_ready  in  ISSUE_WIDTH  issue port k may accept a uop this cycle.
REQ-010 flush  in  1  pipeline flush.
REQ-011 slot_grant  out  NUM_SLOTS  per-slot io_grant, combinational.
REQ-012 issue_valid  out  ISSUE_WIDTH  registered, port k carries an issued uop.
REQ-013 issue_slot_idx  out  ISSUE_WIDTH x clog2(NUM_SLOTS)  registered, granted slot index per port.
REQ-014 issue_pdst  out  ISSUE_WIDTH x 7  registered, pdst of the issued uop.
REQ-015 wakeup_valid, wakeup_pdst  out  ISSUE_WIDTH x (1, 7)  wakeup ports driving the slots' valid/bits_pdst.

Function
REQ-016 The block SHALL hold a round-robin pointer rr_ptr, clog2(NUM_SLOTS) bits; search order is rr_ptr, rr_ptr+1, ... mod NUM_SLOTS.
REQ-017 Each cycle, ready ports in ascending index order SHALL each take the next not-yet-granted requesting slot in search order; a port with fu_ready=0 takes none and does not consume a slot.
REQ-018 slot_grant SHALL be one-hot per granted slot, at most ISSUE_WIDTH bits set, never set for a slot with slot_request=0, and generated in the same cycle as the request.
REQ-019 When fewer requests than ready ports exist, the unused ready ports SHALL have no grant and issue_valid=0 next cycle.
REQ-020 On the edge after a grant, issue_valid[k]=1, issue_slot_idx[k] and issue_pdst[k] SHALL reflect the slot granted to port k (1-cycle latency); otherwise issue_valid[k]=0.
REQ-021 After any cycle with one or more grants, rr_ptr SHALL become (highest-order granted index in search order + 1) mod NUM_SLOTS, wrapping from NUM_SLOTS-1 to 0; otherwise it SHALL hold.
REQ-022 A grant on port k with slot_dst_valid=1 SHALL enter a WAKEUP_LATENCY-deep shift pipeline; wakeup_valid[k]=1 with that pdst exactly WAKEUP_LATENCY cycles after the grant cycle.
REQ-023 A grant with slot_dst_valid=0 SHALL issue normally but produce no wakeup.
REQ-024 flush=1 SHALL force slot_grant to 0 that cycle, and on the next edge clear issue_valid, all wakeup pipeline stages, and set rr_ptr to 0.
REQ-025 Simultaneous flush and fu_ready/requests: flush SHALL win; no grant, no issue, no wakeup from that cycle.

Reset
REQ-026 While reset=0: slot_grant=0, issue_valid=0, issue_slot_idx=0, issue_pdst=0, wakeup_valid=0, wakeup_pdst=0, rr_ptr=0, all pipeline stages cleared, applied asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard in-flight wakeups; the first grant is possible in the first cycle after reset deassertion.

Verification
REQ-028 rr_ptr=0, slot_request=8'b0010_0110, fu_ready=2'b11 -> slot_grant=8'b0000_0110; next cycle issue_slot_idx={2,1}, rr_ptr=3.
REQ-029 Same requests held, rr_ptr=3 -> grants slots 5 and 1 (wrap); rr_ptr becomes 2.
REQ-030 fu_ready=2'b10, slot_request=8'b0000_1000 -> port 1 granted slot 3, issue_valid=2'b10, port 0 idle.
REQ-031 Grant slot 4 with pdst=7'd37, dst_valid=1, WAKEUP_LATENCY=2 -> wakeup_valid[0]=1, wakeup_pdst[0]=37 exactly 2 cycles later, 0 otherwise; with dst_valid=0 -> no wakeup.
REQ-032 Grant in cycle N, flush in cycle N+1 with WAKEUP_LATENCY=2 -> wakeup for the cycle-N grant never appears; slot_grant=0 in N+1; rr_ptr=0 after.
REQ-033 reset=0 asserted between edges with a wakeup in flight -> all outputs 0 immediately; after deassertion with slot_request=8'hFF, fu_ready=2'b11 -> grants slots 0 and 1.
